// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its downstream conflict monitor.
package traffic_pkg;

  localparam int unsigned LAMP_W = 3;
  localparam int unsigned FC_W   = 3;

  typedef logic [LAMP_W-1:0] lamp_t;

  localparam lamp_t LAMP_OFF    = 3'b000;
  localparam lamp_t LAMP_GREEN  = 3'b001;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_RED    = 3'b100;

  typedef enum logic [1:0] {
    PASS    = 2'd0,
    SUSPECT = 2'd1,
    FLASH   = 2'd2,
    RECOVER = 2'd3
  } mode_e;

  localparam int unsigned FC_ILL = 0;
  localparam int unsigned FC_MG  = 1;
  localparam int unsigned FC_WD  = 2;

  typedef struct packed {
    lamp_t left;
    lamp_t right;
    lamp_t straight;
    lamp_t back;
  } lamp_set_t;

  localparam lamp_set_t LAMPS_ALL_RED = '{LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED};
  localparam lamp_set_t LAMPS_ALL_OFF = '{LAMP_OFF, LAMP_OFF, LAMP_OFF, LAMP_OFF};

  function automatic logic lamp_legal(input lamp_t code);
    return (code == LAMP_GREEN) || (code == LAMP_YELLOW) || (code == LAMP_RED);
  endfunction

endpackage

// File: rtl/signal_conflict_monitor_if.sv
// Controller-to-monitor lamp bus: raw codes and clear in, driven lamps and status out.
interface signal_conflict_monitor_if;
  import traffic_pkg::*;

  lamp_t       light_path_left_in;
  lamp_t       light_path_right_in;
  lamp_t       light_straight_in;
  lamp_t       light_back_in;
  logic        fault_clr;
  lamp_t       lamp_left;
  lamp_t       lamp_right;
  lamp_t       lamp_straight;
  lamp_t       lamp_back;
  logic        fault;
  logic [FC_W-1:0] fault_code;
  logic [1:0]  mode;

  modport master (
    output light_path_left_in, light_path_right_in, light_straight_in, light_back_in, fault_clr,
    input  lamp_left, lamp_right, lamp_straight, lamp_back, fault, fault_code, mode
  );

  modport slave (
    input  light_path_left_in, light_path_right_in, light_straight_in, light_back_in, fault_clr,
    output lamp_left, lamp_right, lamp_straight, lamp_back, fault, fault_code, mode
  );

endinterface

// File: rtl/lamp_code_checker.sv
// Combinational legality check of the four approach codes: non-one-hot and conflicting greens.
module lamp_code_checker
  import traffic_pkg::*;
(
  input  lamp_t i_left,
  input  lamp_t i_right,
  input  lamp_t i_straight,
  input  lamp_t i_back,
  output logic  o_ill,
  output logic  o_mg
);

  logic [3:0] w_green;

  assign o_ill = !lamp_legal(i_left) || !lamp_legal(i_right) ||
                 !lamp_legal(i_straight) || !lamp_legal(i_back);

  assign w_green = {i_left == LAMP_GREEN, i_right == LAMP_GREEN,
                    i_straight == LAMP_GREEN, i_back == LAMP_GREEN};

  // Any pair of greens is a conflict.
  assign o_mg = (w_green[0] & w_green[1]) | (w_green[0] & w_green[2]) |
                (w_green[0] & w_green[3]) | (w_green[1] & w_green[2]) |
                (w_green[1] & w_green[3]) | (w_green[2] & w_green[3]);

endmodule

// File: rtl/signal_conflict_monitor.sv
// Safety stage between the traffic controller and the lamps: passes legal codes with one cycle
// of latency and latches a flashing-red failsafe on illegal codes, conflicting greens or a stall.
module signal_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned PERSIST        = 2,
  parameter int unsigned WATCHDOG       = 64,
  parameter int unsigned FLASH_HALF     = 4,
  parameter int unsigned RECOVER_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  signal_conflict_monitor_if.slave  bus
);

  localparam int unsigned PW = $clog2(PERSIST + 1);
  localparam int unsigned WW = $clog2(WATCHDOG);
  localparam int unsigned FW = $clog2(FLASH_HALF + 1);
  localparam int unsigned RW = $clog2(RECOVER_CYCLES + 1);

  localparam logic [PW-1:0] PERSIST_LAST = PW'(PERSIST - 1);
  localparam logic [WW-1:0] WD_MAX       = WW'(WATCHDOG - 1);
  localparam logic [FW-1:0] FLASH_LAST   = FW'(FLASH_HALF - 1);
  localparam logic [RW-1:0] RECOVER_LAST = RW'(RECOVER_CYCLES - 1);

  lamp_set_t       w_in;
  logic            w_ill;
  logic            w_mg;
  logic            w_wd;
  logic            w_in_same;
  logic [FC_W-1:0] w_raw_bits;
  logic            w_raw;
  logic            w_go_flash;
  logic            w_flash_wrap;
  logic            w_phase_nxt;

  mode_e           r_state;
  lamp_set_t       r_lamps;
  lamp_set_t       r_prev;
  logic            r_fault;
  logic [FC_W-1:0] r_code;
  logic [FC_W-1:0] r_pend;
  logic [PW-1:0]   r_pcnt;
  logic [WW-1:0]   r_wcnt;
  logic [FW-1:0]   r_fcnt;
  logic [RW-1:0]   r_rcnt;
  logic            r_phase;

  assign w_in = {bus.light_path_left_in, bus.light_path_right_in,
                 bus.light_straight_in, bus.light_back_in};

  lamp_code_checker u_checker (
    .i_left     (bus.light_path_left_in),
    .i_right    (bus.light_path_right_in),
    .i_straight (bus.light_straight_in),
    .i_back     (bus.light_back_in),
    .o_ill      (w_ill),
    .o_mg       (w_mg)
  );

  assign w_in_same = (w_in == r_prev);
  assign w_wd      = w_in_same && (r_wcnt == WD_MAX);

  always_comb begin
    w_raw_bits         = '0;
    w_raw_bits[FC_ILL] = w_ill;
    w_raw_bits[FC_MG]  = w_mg;
    w_raw_bits[FC_WD]  = w_wd;
  end

  assign w_raw = |w_raw_bits;

  // States that fall into FLASH this edge; FLASH itself stays put on a fault.
  always_comb begin
    w_go_flash = 1'b0;
    case (r_state)
      PASS:    w_go_flash = w_raw && (PERSIST == 1);
      SUSPECT: w_go_flash = w_raw && (r_pcnt == PERSIST_LAST);
      RECOVER: w_go_flash = w_raw;
      default: w_go_flash = 1'b0;
    endcase
  end

  assign w_flash_wrap = (r_fcnt == FLASH_LAST);
  assign w_phase_nxt  = w_flash_wrap ? ~r_phase : r_phase;

  // Stall watchdog: counts cycles of an unchanged input word, runs in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_wcnt <= '0;
    end else begin
      r_prev <= w_in;
      if (!w_in_same)
        r_wcnt <= '0;
      else if (r_wcnt != WD_MAX)
        r_wcnt <= r_wcnt + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RECOVER;
      r_lamps <= LAMPS_ALL_RED;
      r_fault <= 1'b0;
      r_code  <= '0;
      r_pend  <= '0;
      r_pcnt  <= '0;
      r_fcnt  <= '0;
      r_rcnt  <= '0;
      r_phase <= 1'b1;
    end else if (w_go_flash) begin
      r_state <= FLASH;
      r_fault <= 1'b1;
      r_code  <= r_pend | w_raw_bits;
      r_pend  <= '0;
      r_pcnt  <= '0;
      r_fcnt  <= '0;
      r_phase <= 1'b1;
      r_lamps <= LAMPS_ALL_RED;
    end else begin
      case (r_state)
        PASS: begin
          if (w_raw) begin
            r_state <= SUSPECT;
            r_pcnt  <= PW'(1);
            r_pend  <= w_raw_bits;
          end else begin
            r_lamps <= w_in;
          end
        end
        SUSPECT: begin
          if (w_raw) begin
            r_pcnt <= r_pcnt + PW'(1);
            r_pend <= r_pend | w_raw_bits;
          end else begin
            r_state <= PASS;
            r_pcnt  <= '0;
            r_pend  <= '0;
            r_lamps <= w_in;
          end
        end
        FLASH: begin
          // A clear only counts on a clean cycle; a coincident fault keeps the latch.
          if (!w_raw && bus.fault_clr) begin
            r_state <= RECOVER;
            r_fault <= 1'b0;
            r_code  <= '0;
            r_rcnt  <= '0;
            r_lamps <= LAMPS_ALL_RED;
          end else begin
            r_fcnt  <= w_flash_wrap ? '0 : r_fcnt + FW'(1);
            r_phase <= w_phase_nxt;
            r_lamps <= w_phase_nxt ? LAMPS_ALL_RED : LAMPS_ALL_OFF;
          end
        end
        RECOVER: begin
          if (r_rcnt == RECOVER_LAST) begin
            r_state <= PASS;
            r_rcnt  <= '0;
            r_lamps <= w_in;
          end else begin
            r_rcnt <= r_rcnt + RW'(1);
          end
        end
        default: r_state <= RECOVER;
      endcase
    end
  end

  assign bus.lamp_left     = r_lamps.left;
  assign bus.lamp_right    = r_lamps.right;
  assign bus.lamp_straight = r_lamps.straight;
  assign bus.lamp_back     = r_lamps.back;
  assign bus.fault         = r_fault;
  assign bus.fault_code    = r_code;
  assign bus.mode          = r_state;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Scoreboard bench for signal_conflict_monitor: a behavioural model pushes the expected
// post-edge outputs for every driven cycle; they are popped and compared after the edge.
module tb_signal_conflict_monitor;
  import traffic_pkg::*;

  localparam int unsigned PERSIST        = 2;
  localparam int unsigned WATCHDOG       = 64;
  localparam int unsigned FLASH_HALF     = 4;
  localparam int unsigned RECOVER_CYCLES = 8;

  localparam logic [11:0] ALL_RED = 12'h924;

  typedef struct packed {
    logic [11:0] lamps;
    logic        fault;
    logic [2:0]  code;
    logic [1:0]  mode;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  signal_conflict_monitor_if u_if ();

  signal_conflict_monitor #(
    .PERSIST        (PERSIST),
    .WATCHDOG       (WATCHDOG),
    .FLASH_HALF     (FLASH_HALF),
    .RECOVER_CYCLES (RECOVER_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [11:0] pats [8];

  // Model state
  int          m_state;
  logic [11:0] m_lamps;
  logic [11:0] m_prev;
  logic        m_fault;
  logic [2:0]  m_code;
  logic [2:0]  m_pend;
  logic        m_on;
  int          m_pcnt, m_wcnt, m_fcnt, m_rcnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal_code(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
  endfunction

  task automatic model_reset();
    m_state = 3; m_lamps = ALL_RED; m_prev = '0; m_fault = 1'b0; m_code = '0; m_pend = '0;
    m_on = 1'b1; m_pcnt = 0; m_wcnt = 0; m_fcnt = 0; m_rcnt = 0;
  endtask

  task automatic model_trip(input logic [2:0] rb);
    m_state = 2; m_fault = 1'b1; m_code = m_pend | rb; m_pend = '0; m_pcnt = 0;
    m_fcnt = 0; m_on = 1'b1; m_lamps = ALL_RED;
  endtask

  task automatic model_step(input logic [11:0] in, input logic clr);
    logic [2:0] rb;
    logic [2:0] c;
    int greens;
    rb = '0;
    greens = 0;
    for (int i = 0; i < 4; i++) begin
      c = in[i*3 +: 3];
      if (!legal_code(c)) rb[0] = 1'b1;
      if (c == 3'b001) greens++;
    end
    if (greens >= 2) rb[1] = 1'b1;
    if (in == m_prev && m_wcnt == WATCHDOG - 1) rb[2] = 1'b1;
    if (in != m_prev) m_wcnt = 0;
    else if (m_wcnt < WATCHDOG - 1) m_wcnt++;
    m_prev = in;
    case (m_state)
      0: begin
        if (rb == 0) m_lamps = in;
        else if (PERSIST == 1) model_trip(rb);
        else begin m_state = 1; m_pcnt = 1; m_pend = rb; end
      end
      1: begin
        if (rb != 0) begin
          m_pcnt++;
          if (m_pcnt >= PERSIST) model_trip(rb);
          else m_pend = m_pend | rb;
        end else begin
          m_state = 0; m_pcnt = 0; m_pend = '0; m_lamps = in;
        end
      end
      2: begin
        if (rb == 0 && clr) begin
          m_state = 3; m_fault = 1'b0; m_code = '0; m_rcnt = 0; m_lamps = ALL_RED;
        end else begin
          m_fcnt++;
          if (m_fcnt == FLASH_HALF) begin m_fcnt = 0; m_on = ~m_on; end
          m_lamps = m_on ? ALL_RED : 12'h000;
        end
      end
      default: begin
        if (rb != 0) model_trip(rb);
        else begin
          m_rcnt++;
          if (m_rcnt == RECOVER_CYCLES) begin m_state = 0; m_rcnt = 0; m_lamps = in; end
        end
      end
    endcase
  endtask

  function automatic logic [11:0] dut_lamps();
    return {u_if.lamp_left, u_if.lamp_right, u_if.lamp_straight, u_if.lamp_back};
  endfunction

  // One clock: drive, predict, wait for the edge, compare against the queued prediction.
  task automatic cycle(input logic [11:0] in, input logic clr, input string tag);
    exp_t e;
    u_if.light_path_left_in  = in[11:9];
    u_if.light_path_right_in = in[8:6];
    u_if.light_straight_in   = in[5:3];
    u_if.light_back_in       = in[2:0];
    u_if.fault_clr           = clr;
    model_step(in, clr);
    sb_q.push_back('{m_lamps, m_fault, m_code, m_state[1:0]});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, ".lamps"}, 32'(dut_lamps()), 32'(e.lamps));
      check_eq({tag, ".fault"}, 32'(u_if.fault), 32'(e.fault));
      check_eq({tag, ".code"},  32'(u_if.fault_code), 32'(e.code));
      check_eq({tag, ".mode"},  32'(u_if.mode), 32'(e.mode));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".lamps"}, 32'(dut_lamps()), 32'(ALL_RED));
    check_eq({tag, ".fault"}, 32'(u_if.fault), 32'd0);
    check_eq({tag, ".code"},  32'(u_if.fault_code), 32'd0);
    check_eq({tag, ".mode"},  32'(u_if.mode), 32'd3);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    model_reset();
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] v;
    bit hit;
    pats[0] = {3'b001, 3'b100, 3'b100, 3'b100};
    pats[1] = {3'b010, 3'b100, 3'b100, 3'b100};
    pats[2] = {3'b100, 3'b001, 3'b100, 3'b100};
    pats[3] = {3'b100, 3'b010, 3'b100, 3'b100};
    pats[4] = {3'b100, 3'b100, 3'b001, 3'b100};
    pats[5] = {3'b100, 3'b100, 3'b010, 3'b100};
    pats[6] = {3'b100, 3'b100, 3'b100, 3'b001};
    pats[7] = {3'b100, 3'b100, 3'b100, 3'b010};

    rst_n = 1'b0;
    u_if.light_path_left_in  = 3'b001;
    u_if.light_path_right_in = 3'b010;
    u_if.light_straight_in   = 3'b100;
    u_if.light_back_in       = 3'b100;
    u_if.fault_clr           = 1'b0;
    #12;
    check_reset_values("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery after reset, then pass-through of cycling legal codes
    for (int i = 0; i < 16; i++) cycle(pats[i % 8], 1'b0, "boot");

    // One-cycle illegal code on the left approach
    cycle({3'b011, 3'b100, 3'b100, 3'b100}, 1'b0, "glitch");
    check_eq("glitch_mode", 32'(u_if.mode), 32'd1);
    cycle(pats[2], 1'b0, "glitch");
    check_eq("glitch_fault", 32'(u_if.fault), 32'd0);
    for (int i = 0; i < 3; i++) cycle(pats[i + 3], 1'b0, "glitch");

    // Conflicting greens for two cycles, flash pattern, ignored clear, accepted clear
    v = {3'b001, 3'b100, 3'b001, 3'b100};
    cycle(v, 1'b0, "mg");
    cycle(v, 1'b0, "mg");
    check_eq("mg_mode", 32'(u_if.mode), 32'd2);
    check_eq("mg_code", 32'(u_if.fault_code), 32'd2);
    for (int i = 0; i < 10; i++) cycle(v, 1'b0, "mg_flash");
    cycle(v, 1'b1, "clr_bad");
    check_eq("clr_bad_mode", 32'(u_if.mode), 32'd2);
    check_eq("clr_bad_fault", 32'(u_if.fault), 32'd1);
    cycle(pats[0], 1'b1, "clr_ok");
    check_eq("clr_ok_mode", 32'(u_if.mode), 32'd3);
    for (int i = 0; i < 10; i++) cycle(pats[(i + 1) % 8], 1'b0, "recover");

    // Stalled controller
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      cycle(pats[5], 1'b0, "wd");
      if (u_if.mode == 2'd2) hit = 1'b1;
    end
    check_eq("wd_trip", 32'(hit), 32'd1);
    check_eq("wd_code", 32'(u_if.fault_code), 32'd4);
    cycle(pats[6], 1'b1, "wd_clr");
    for (int i = 0; i < 10; i++) cycle(pats[i % 8], 1'b0, "wd_recover");

    // Asynchronous reset in the middle of FLASH, then in the middle of RECOVER
    v = {3'b000, 3'b100, 3'b100, 3'b100};
    cycle(v, 1'b0, "ill");
    cycle(v, 1'b0, "ill");
    for (int i = 0; i < 3; i++) cycle(pats[i], 1'b0, "ill_flash");
    async_reset("rst_flash");
    for (int i = 0; i < 3; i++) cycle(pats[i], 1'b0, "rst_rec");
    async_reset("rst_recover");
    for (int i = 0; i < 10; i++) cycle(pats[i % 8], 1'b0, "after_rst");

    // Randomised mix of legal, illegal and conflicting codes with random clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 8) v = pats[$urandom_range(0, 7)];
      else v = 12'($urandom);
      cycle(v, ($urandom_range(0, 3) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
